stage_sequencer: RTL
====================

// Module: stage_sequencer
// PURPOSE
//   Job-level controller for the StageClock stage generator. Accepts a job (pass
//   count) over a valid/ready handshake and drives StageClock start/shift. Runs
//   NUM_STAGES shift cycles per pass, honours a downstream hold and signals done.
//   Sits between the control FSM and StageClock; StageClock is instantiated by the parent.
// PARAMETERS
//   NUM_STAGES  6  stages per pass; matches StageClock out width
//   PASS_W      8  width of the requested pass count
// PORTS
//   clk          in   1           single clock, rising edge
//   rst          in   1           synchronous, active-high reset
//   req_valid    in   1           job request valid
//   req_passes   in   PASS_W      passes for the job; sampled on acceptance
//   req_ready    out  1           high only in IDLE with abort low
//   hold         in   1           downstream stall; freezes stage progress in RUN
//   abort        in   1           synchronous job cancel
//   stage_start  out  1           one-cycle start pulse to StageClock
//   stage_shift  out  1           shift enable to StageClock
//   stage_idx    out  $clog2(NUM_STAGES)  current stage within the pass
//   pass_cnt     out  PASS_W      passes completed in the current job
//   busy         out  1           high in START/RUN
//   done         out  1           one-cycle pulse when a job completes
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0 except req_ready=1. Latched passes cleared.
//   FSM states are IDLE, START, RUN and DONE. Outputs are registered; transitions below.
//   - IDLE: accept on req_valid&&req_ready; latch req_passes and clear pass_cnt.
//     If req_passes==0, go to DONE. Otherwise go to START.
//   - START: stage_start=1, stage_shift=0, stage_idx=0; go to RUN.
//     hold has no effect here.
//   - RUN, hold=0: stage_shift=1 and stage_idx++.
//     At stage_idx==NUM_STAGES-1: stage_idx wraps to 0 and pass_cnt++.
//     If pass_cnt+1==passes, go to DONE; else go to START for the next pass.
//   - RUN, hold=1: stage_shift=0; stage_idx and pass_cnt are frozen.
//   - DONE: done=1 for one cycle; go to IDLE. pass_cnt stays valid until the next accept.
//   Latency: accept at cycle N -> stage_start at N+1, first shift at N+2.
//     With no hold, done asserts at N+1+P*(NUM_STAGES+1).
//     Each hold cycle in RUN adds 1 cycle.
//   - pass_cnt saturates at all-ones; P=2^PASS_W-1 is legal.
//   - abort: any state -> IDLE next cycle. stage_start, stage_shift and done are forced 0 that cycle.
//     No done pulse for an aborted job. abort in IDLE beats req_valid (no accept).
//   - rst mid-job: same as reset. No done pulse.
//   - req_valid while busy: ignored (req_ready=0). The request is held by the requester.
// CONFIGURATION
//   STAGE_SEQ_STALL_CNT_EN defined:
//     adds output stall_cycles[15:0], a count of hold cycles seen in RUN.
//     Saturates at 16'hFFFF, clears on job acceptance, resets to 0.
//     The count stays readable after done until the next accept.
//   STAGE_SEQ_STALL_CNT_EN undefined:
//     the port and its counter are absent. All other behaviour is identical.
// STRUCTURE
//   stage_seq_pkg holds the state enum typedef stage_seq_state_t (IDLE, START,
//   RUN, DONE) and localparam NUM_STAGES_DEFAULT=6.
//   Sub-module stage_seq_sat_cnt is a parameterised-width saturating counter
//   with clr/inc. It is used for pass_cnt and, under the macro, for stall_cycles.
//   FSM and stage index stay in stage_sequencer.
// TESTING
//   1. Reset, then req_valid=1, passes=1, hold=0. Required: stage_start 1 cycle
//      after accept, then 6 stage_shift cycles with stage_idx 0..5, done at N+8,
//      and req_ready=1 again at N+9.
//   2. passes=3, no hold. Required: 3 start pulses spaced 7 cycles apart,
//      pass_cnt ends at 3, and done at N+22.
//   3. passes=2 with hold=1 for 4 cycles at stage_idx=3 of pass 0. Required:
//      stage_shift=0 and idx frozen at 3 during hold, and done at N+19.
//      stall_cycles=4 when the macro is defined.
//   4. passes=0. Required: no stage_start and no stage_shift, done at N+1,
//      pass_cnt=0.
//   5. abort at stage_idx=2 of pass 1 of a 4-pass job. Required: IDLE next cycle,
//      shift 0, no done pulse, and a new request accepted the cycle after.
//   6. rst asserted mid-RUN, and abort together with req_valid in IDLE. Required:
//      all outputs at reset values. The abort-in-IDLE request is not accepted;
//      it is accepted the following cycle.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// stage_seq_pkg: shared types and defaults for the stage sequencer slice.
package stage_seq_pkg;

  // Job-level controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } stage_seq_state_t;

  localparam int NUM_STAGES_DEFAULT = 6;
  localparam int PASS_W_DEFAULT     = 8;
  localparam int STALL_W            = 16;

endpackage

// File: rtl/stage_seq_sat_cnt.sv
// stage_seq_sat_cnt: parameterised-width up counter that sticks at all-ones.
// clr has priority over inc.
module stage_seq_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: job-level controller for the StageClock stage generator.
// Accepts a pass count over valid/ready, then for each pass issues one start
// pulse followed by NUM_STAGES shift cycles, honouring hold and abort.
// Optional feature macro: STAGE_SEQ_STALL_CNT_EN adds the stall_cycles output.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int PASS_W     = PASS_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [PASS_W-1:0]             req_passes,
  output logic                          req_ready,
  input  logic                          hold,
  input  logic                          abort,
  output logic                          stage_start,
  output logic                          stage_shift,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic [PASS_W-1:0]             pass_cnt,
  output logic                          busy,
  output logic                          done
`ifdef STAGE_SEQ_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0]            stall_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  stage_seq_state_t  state_q, state_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              start_q, start_d;
  logic              shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              pass_end;
  logic              pass_inc;
  logic              last_pass;
  logic [PASS_W-1:0] pass_cnt_w;
  logic [PASS_W:0]   pass_next;

  assign req_ready = (state_q == IDLE) && !abort;
  assign accept    = req_valid && req_ready;
  assign pass_end  = (state_q == RUN) && !hold && (idx_q == IDX_LAST);
  assign pass_inc  = pass_end && !abort;
  assign pass_next = {1'b0, pass_cnt_w} + (PASS_W + 1)'(1);
  assign last_pass = (pass_next == {1'b0, passes_q});

  // Next state, stage index and registered output strobes; abort overrides all.
  always_comb begin
    state_d  = state_q;
    passes_d = passes_q;
    idx_d    = idx_q;
    shift_d  = 1'b0;
    start_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          passes_d = req_passes;
          idx_d    = '0;
          state_d  = (req_passes == '0) ? DONE : START;
        end
      end
      START: begin
        idx_d   = '0;
        shift_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (!hold) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = last_pass ? DONE : START;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    start_d = (state_d == START);
    busy_d  = (state_d == START) || (state_d == RUN);
    done_d  = (state_d == DONE);
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      start_d = 1'b0;
      shift_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State, latched pass count, stage index and output strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      passes_q <= '0;
      idx_q    <= '0;
      start_q  <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      passes_q <= passes_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  stage_seq_sat_cnt #(.W(PASS_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (pass_inc),
    .count (pass_cnt_w)
  );

`ifdef STAGE_SEQ_STALL_CNT_EN
  stage_seq_sat_cnt #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   ((state_q == RUN) && hold),
    .count (stall_cycles)
  );
`endif

  assign stage_start = start_q;
  assign stage_shift = shift_q;
  assign stage_idx   = idx_q;
  assign pass_cnt    = pass_cnt_w;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
